// File: rtl/axis_sniffer_fifo_pkg.sv
// Purpose : shared defaults for the AXIS sniffer block (parameter defaults only).
// Latency : n/a (package).
// Backpressure: n/a (package).
package axis_sniffer_fifo_pkg;

  localparam int unsigned DEF_TDATA_WIDTH    = 32;
  localparam int unsigned DEF_FIFO_DEPTH_LOG2 = 4;
  localparam int unsigned DEF_DECIM_WIDTH    = 16;
  localparam int unsigned DEF_DROP_CNT_WIDTH = 32;

endpackage

// File: rtl/axis_sniffer_sync_fifo.sv
// Purpose : synchronous first-word-fall-through FIFO holding sniffed beats.
// Latency : push visible on head_data/empty one cycle later; pop is same-cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports   : aclk/reset (sync, active-high), push/push_data, pop,
//           full/empty/level status, head_data = entry at the read pointer.
module axis_sniffer_sync_fifo
  import axis_sniffer_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int unsigned DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int unsigned      DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rd_en, wr_en;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign level     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO is still
  // legal when it coincides with a pop (write lands where the head was).
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q != 0.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axis_sniffer_fifo.sv
// Purpose : zero-latency AXIS pass-through that copies every (decimation+1)-th accepted beat into a sniff FIFO.
// Latency : main path combinational; capture reaches MS_AXIS one cycle later when the FIFO is empty.
// Backpressure: main path never stalled by the sniff side; captures into a full FIFO are dropped and counted.
// Ports   : aclk/reset (sync, active-high), enable/decimation control,
//           S_AXIS slave -> M_AXIS master (wired through), MS_AXIS sniff master,
//           fifo_level occupancy, drop_count saturating lost-capture counter.
module axis_sniffer_fifo
  import axis_sniffer_fifo_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int unsigned FIFO_DEPTH_LOG2  = DEF_FIFO_DEPTH_LOG2,
  parameter int unsigned DECIM_WIDTH      = DEF_DECIM_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH   = DEF_DROP_CNT_WIDTH
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [DECIM_WIDTH-1:0]      decimation,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  input  logic                        MS_AXIS_tready,
  output logic                        MS_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] MS_AXIS_tdata,
  output logic [FIFO_DEPTH_LOG2:0]    fifo_level,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count
);

  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

  logic                      acc, capture, pop, push, drop;
  logic                      fifo_full, fifo_empty;
  logic [DECIM_WIDTH-1:0]    dcnt_q, dcnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Main path is pure wiring, independent of reset, enable and FIFO state.
  assign M_AXIS_tvalid = S_AXIS_tvalid;
  assign M_AXIS_tdata  = S_AXIS_tdata;
  assign S_AXIS_tready = M_AXIS_tready;

  assign acc     = S_AXIS_tvalid & M_AXIS_tready;
  assign capture = acc & enable & (dcnt_q == '0);
  assign pop     = MS_AXIS_tready & ~fifo_empty;
  assign push    = capture & (~fifo_full | pop);
  assign drop    = capture & fifo_full & ~pop;

  // dcnt is held at zero while disabled so the first beat after enable
  // rises is captured; decimation is only sampled on reload.
  always_comb begin
    dcnt_d = dcnt_q;
    if (!enable)          dcnt_d = '0;
    else if (acc)         dcnt_d = (dcnt_q == '0) ? decimation : dcnt_q - 1'b1;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      dcnt_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      dcnt_q     <= dcnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count     = drop_cnt_q;
  assign MS_AXIS_tvalid = ~fifo_empty;

  axis_sniffer_sync_fifo #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .aclk      (aclk),
    .reset     (reset),
    .push      (push),
    .push_data (S_AXIS_tdata),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head_data (MS_AXIS_tdata)
  );

endmodule

// File: tb/tb_axis_sniffer_fifo.sv
// Purpose : self-checking bench for axis_sniffer_fifo (depth 4 build).
// Latency : n/a.
// Backpressure: n/a.
module tb_axis_sniffer_fifo;

  logic        aclk;
  logic        reset;
  logic        enable;
  logic [15:0] decimation;
  logic        S_AXIS_tvalid;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tready;
  logic        M_AXIS_tready;
  logic        M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        MS_AXIS_tready;
  logic        MS_AXIS_tvalid;
  logic [31:0] MS_AXIS_tdata;
  logic [2:0]  fifo_level;
  logic [31:0] drop_count;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic        mr;
    logic        ev;
    logic [31:0] ed;
    logic        er;
  } vec_t;
  vec_t vecs [6];

  axis_sniffer_fifo #(
    .AXIS_TDATA_WIDTH (32),
    .FIFO_DEPTH_LOG2  (2),
    .DECIM_WIDTH      (16),
    .DROP_CNT_WIDTH   (32)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .enable         (enable),
    .decimation     (decimation),
    .S_AXIS_tvalid  (S_AXIS_tvalid),
    .S_AXIS_tdata   (S_AXIS_tdata),
    .S_AXIS_tready  (S_AXIS_tready),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .MS_AXIS_tready (MS_AXIS_tready),
    .MS_AXIS_tvalid (MS_AXIS_tvalid),
    .MS_AXIS_tdata  (MS_AXIS_tdata),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record every sniff handshake; inputs only change just after posedge,
  // so the negedge view is what the next posedge will accept.
  always @(negedge aclk) begin
    if (!reset && MS_AXIS_tvalid && MS_AXIS_tready) got_q.push_back(MS_AXIS_tdata);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name);
    logic [31:0] a;
    chk({name, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF;
      chk($sformatf("%s[%0d]", name, i), 64'(a), 64'(exp_q[i]));
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = d;
    step();
  endtask

  initial begin
    int exp_drop;

    vecs[0] = '{tv:1'b1, td:32'h1111_0001, mr:1'b1, ev:1'b1, ed:32'h1111_0001, er:1'b1};
    vecs[1] = '{tv:1'b1, td:32'h2222_0002, mr:1'b0, ev:1'b1, ed:32'h2222_0002, er:1'b0};
    vecs[2] = '{tv:1'b0, td:32'h3333_0003, mr:1'b1, ev:1'b0, ed:32'h3333_0003, er:1'b1};
    vecs[3] = '{tv:1'b0, td:32'h4444_0004, mr:1'b0, ev:1'b0, ed:32'h4444_0004, er:1'b0};
    vecs[4] = '{tv:1'b1, td:32'hFFFF_FFFF, mr:1'b1, ev:1'b1, ed:32'hFFFF_FFFF, er:1'b1};
    vecs[5] = '{tv:1'b1, td:32'h0000_0000, mr:1'b0, ev:1'b1, ed:32'h0000_0000, er:1'b0};

    reset = 1'b1; enable = 1'b0; decimation = '0;
    S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0;
    M_AXIS_tready = 1'b0; MS_AXIS_tready = 1'b0;
    repeat (2) step();

    // Reset state, and main path live during reset
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'hA5A5_0000; M_AXIS_tready = 1'b1;
    #1;
    chk("rst_pass_data", 64'(M_AXIS_tdata), 64'h A5A5_0000);
    chk("rst_pass_ready", 64'(S_AXIS_tready), 64'd1);
    step();
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ms_valid", 64'(MS_AXIS_tvalid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0; S_AXIS_tvalid = 1'b0;
    step();

    // Decimation 2 with an always-ready consumer
    enable = 1'b1; decimation = 16'd2; MS_AXIS_tready = 1'b1; got_q.delete();
    for (int i = 0; i < 12; i++) send(32'(i));
    S_AXIS_tvalid = 1'b0;
    repeat (4) step();
    exp_q = {32'd0, 32'd3, 32'd6, 32'd9};
    chk_seq("decim2");
    chk("decim2_drop", 64'(drop_count), 64'd0);
    chk("decim2_level", 64'(fifo_level), 64'd0);

    // Overfill a depth-4 FIFO with a stalled consumer
    enable = 1'b0; step();
    enable = 1'b1; decimation = '0; MS_AXIS_tready = 1'b0; got_q.delete();
    for (int i = 0; i < 6; i++) send(32'(10 + i));
    S_AXIS_tvalid = 1'b0;
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_drop", 64'(drop_count), 64'd2);
    chk("full_valid", 64'(MS_AXIS_tvalid), 64'd1);
    chk("full_head", 64'(MS_AXIS_tdata), 64'd10);
    step();
    chk("full_head_stable", 64'(MS_AXIS_tdata), 64'd10);
    MS_AXIS_tready = 1'b1;
    repeat (5) step();
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_valid", 64'(MS_AXIS_tvalid), 64'd0);
    exp_q = {32'd10, 32'd11, 32'd12, 32'd13};
    chk_seq("drain");

    // Refill; capture into empty FIFO is visible one cycle later
    MS_AXIS_tready = 1'b0; got_q.delete();
    send(32'd20);
    chk("lat_valid", 64'(MS_AXIS_tvalid), 64'd1);
    chk("lat_level", 64'(fifo_level), 64'd1);
    chk("lat_head", 64'(MS_AXIS_tdata), 64'd20);
    send(32'd21); send(32'd22); send(32'd23);
    chk("refill_level", 64'(fifo_level), 64'd4);

    // Full FIFO: pop and capture in the same cycle
    MS_AXIS_tready = 1'b1;
    send(32'd24);
    MS_AXIS_tready = 1'b0; S_AXIS_tvalid = 1'b0;
    chk("pp_level", 64'(fifo_level), 64'd4);
    chk("pp_drop", 64'(drop_count), 64'd2);
    chk("pp_head", 64'(MS_AXIS_tdata), 64'd21);

    // Pass-through table with the FIFO full and the consumer stalled
    exp_drop = 2;
    for (int i = 0; i < 6; i++) begin
      S_AXIS_tvalid = vecs[i].tv;
      S_AXIS_tdata  = vecs[i].td;
      M_AXIS_tready = vecs[i].mr;
      #1;
      chk($sformatf("pt%0d_mvalid", i), 64'(M_AXIS_tvalid), 64'(vecs[i].ev));
      chk($sformatf("pt%0d_mdata", i), 64'(M_AXIS_tdata), 64'(vecs[i].ed));
      chk($sformatf("pt%0d_sready", i), 64'(S_AXIS_tready), 64'(vecs[i].er));
      if (vecs[i].tv && vecs[i].mr) exp_drop++;
      step();
    end
    S_AXIS_tvalid = 1'b0; M_AXIS_tready = 1'b1;
    chk("pt_drop", 64'(drop_count), 64'(exp_drop));
    chk("pt_level", 64'(fifo_level), 64'd4);
    MS_AXIS_tready = 1'b1;
    repeat (6) step();
    exp_q = {32'd20, 32'd21, 32'd22, 32'd23, 32'd24};
    chk_seq("pp_drain");

    // Enable rises at beat 5, decimation 3
    enable = 1'b0; decimation = 16'd3; step(); got_q.delete();
    for (int i = 0; i < 14; i++) begin
      enable = (i >= 5);
      send(32'(i));
    end
    S_AXIS_tvalid = 1'b0;
    repeat (3) step();
    exp_q = {32'd5, 32'd9, 32'd13};
    chk_seq("en_decim3");

    // Decimation changed to 0 after beat 5: takes effect at next reload
    enable = 1'b0; decimation = 16'd3; step(); got_q.delete();
    for (int i = 0; i < 16; i++) begin
      enable = (i >= 5);
      if (i >= 6) decimation = '0;
      send(32'(i));
    end
    S_AXIS_tvalid = 1'b0;
    repeat (3) step();
    exp_q = {32'd5, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    chk_seq("en_decim_chg");

    // Reset mid-operation with entries queued and main traffic running
    MS_AXIS_tready = 1'b0; decimation = '0; got_q.delete();
    send(32'd30); send(32'd31); send(32'd32);
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    reset = 1'b1; S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'd40;
    #1;
    chk("mid_rst_mdata", 64'(M_AXIS_tdata), 64'd40);
    chk("mid_rst_mvalid", 64'(M_AXIS_tvalid), 64'd1);
    step();
    chk("post_rst_valid", 64'(MS_AXIS_tvalid), 64'd0);
    chk("post_rst_level", 64'(fifo_level), 64'd0);
    chk("post_rst_drop", 64'(drop_count), 64'd0);
    S_AXIS_tdata = 32'd41;
    #1;
    chk("mid_rst_mdata2", 64'(M_AXIS_tdata), 64'd41);
    reset = 1'b0; S_AXIS_tvalid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_sniffer_fifo.md
Name: axis_sniffer_fifo

Overview:
Parametrised successor to the plain AXIS tap. The main stream passes through with zero latency and is never stalled by the sniff side. Every Nth accepted beat is copied into an internal FIFO and presented on a separate sniff master. This lets a slow consumer (DMA or register readout) sample the signal chain without back-pressuring it. Dropped samples (FIFO full) are counted.

Parameters:
AXIS_TDATA_WIDTH, 32, data width of all three streams
FIFO_DEPTH_LOG2, 4, sniff FIFO depth = 2**FIFO_DEPTH_LOG2 entries (min 1)
DECIM_WIDTH, 16, width of decimation control and counter
DROP_CNT_WIDTH, 32, width of saturating drop counter

Ports:
aclk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high
enable  in  1  sniff capture enable; main path unaffected
decimation  in  DECIM_WIDTH  capture 1 of (decimation+1) accepted beats; 0 = every beat
S_AXIS_tvalid  in  1  upstream valid
S_AXIS_tdata  in  AXIS_TDATA_WIDTH  upstream data
S_AXIS_tready  out  1  upstream ready
M_AXIS_tready  in  1  main downstream ready
M_AXIS_tvalid  out  1  main downstream valid
M_AXIS_tdata  out  AXIS_TDATA_WIDTH  main downstream data
MS_AXIS_tready  in  1  sniff consumer ready
MS_AXIS_tvalid  out  1  sniff valid (FIFO not empty)
MS_AXIS_tdata  out  AXIS_TDATA_WIDTH  sniff data (FIFO head)
fifo_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
drop_count  out  DROP_CNT_WIDTH  saturating count of captures lost to full FIFO

Behaviour:
- Main path is combinational: M_AXIS_tvalid=S_AXIS_tvalid, M_AXIS_tdata=S_AXIS_tdata, S_AXIS_tready=M_AXIS_tready. Its behaviour does not depend on reset, enable or FIFO state.
- Accepted beat: acc = S_AXIS_tvalid & M_AXIS_tready.
- Decimation counter dcnt (DECIM_WIDTH):
  - reset -> 0; enable=0 -> forced to 0.
  - On acc with enable=1: if dcnt==0, issue capture and load dcnt=decimation; else dcnt=dcnt-1.
  - The first accepted beat after reset or after enable rises is always captured.
  - A change to decimation takes effect at the next reload only.
- Push/pop:
  - capture pushes S_AXIS_tdata.
  - pop = MS_AXIS_tvalid & MS_AXIS_tready.
  - Push is accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle.
  - Otherwise the capture is dropped and drop_count increments, saturating at all-ones (no wrap).
- FIFO:
  - Synchronous, memory-based, wrap-around read/write pointers of FIFO_DEPTH_LOG2 bits plus an occupancy counter.
  - MS_AXIS_tvalid = (count!=0).
  - MS_AXIS_tdata = memory[rd_ptr], first-word-fall-through.
  - Capture-to-MS_AXIS_tvalid latency is 1 cycle when empty.
  - MS_AXIS_tdata is stable while MS_AXIS_tvalid=1 and MS_AXIS_tready=0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push and pop at count==0: no pop (tvalid low); the push lands and the count becomes 1.
- Reset values: fifo_level=0, MS_AXIS_tvalid=0, drop_count=0, dcnt=0, pointers=0. MS_AXIS_tdata is don't-care while tvalid=0.
- Reset mid-operation flushes the FIFO contents; the main path continues to pass data during reset.
- enable=0 does not flush. The FIFO keeps draining to the consumer.

Decomposition:
- No shared package required. Local constants: DEPTH = 2**FIFO_DEPTH_LOG2, DROP_MAX = all-ones.
- One sub-module, axis_sniffer_sync_fifo, with ports aclk, reset, push, push_data, pop, full, empty, level, head_data, parametrised by width and depth log2.
- Decimation, drop logic and the main-path wiring stay in the top level.

Test Plan:
- Pass-through: M_AXIS_tready toggles, MS_AXIS_tready=0 with FIFO full -> M_AXIS_tdata/M_AXIS_tvalid equal S_AXIS each cycle; S_AXIS_tready tracks M_AXIS_tready; no stall.
- Decimation=2, enable=1, 12 accepted beats 0..11, sniff always ready -> MS_AXIS delivers 0,3,6,9; drop_count=0.
- FIFO_DEPTH_LOG2=2, decimation=0, MS_AXIS_tready=0, 6 beats -> fifo_level=4, drop_count=2. Then release ready -> MS_AXIS delivers 0,1,2,3 and fifo_level reaches 0.
- Full FIFO with pop and capture in the same cycle -> push accepted, fifo_level stays 4, drop_count unchanged.
- enable low for beats 0..4, high from beat 5, decimation=3 -> captures 5,9,13. Changing decimation to 0 after beat 5 -> next capture still 9, then every beat.
- Reset asserted with 3 entries queued, main traffic running -> next cycle MS_AXIS_tvalid=0, fifo_level=0, drop_count=0; M_AXIS keeps passing data throughout.
